// File: rtl/ice51_mem_arb_pkg.sv
// Shared types and default widths for the ice51 memory arbiter.
package ice51_pkg;

    localparam int CODE_ADDR_W = 10;
    localparam int DATA_ADDR_W = 9;
    localparam int DATA_W      = 8;

    // Arbiter FSM state; encodings kept from the original localparams.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ice51_mem_arb_if.sv
// Requester A/B and memory-side signals of the ice51 memory arbiter.
interface ice51_mem_arb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);

    logic              i_a_req;
    logic              i_a_we;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] i_a_wdata;
    logic              o_a_gnt;
    logic              o_a_rvalid;
    logic [DATA_W-1:0] o_a_rdata;

    logic              i_b_req;
    logic              i_b_we;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] i_b_wdata;
    logic              i_b_lock;
    logic              o_b_gnt;
    logic              o_b_rvalid;
    logic [DATA_W-1:0] o_b_rdata;

    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              o_mem_re;
    logic [DATA_W-1:0] i_mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_a_req, i_a_we, i_a_addr, i_a_wdata,
        output o_a_gnt, o_a_rvalid, o_a_rdata,
        input  i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_lock,
        output o_b_gnt, o_b_rvalid, o_b_rdata,
        output o_mem_we, o_mem_addr, o_mem_wdata, o_mem_re,
        input  i_mem_rdata
    );

    // Requesters plus memory side.
    modport master (
        output i_a_req, i_a_we, i_a_addr, i_a_wdata,
        input  o_a_gnt, o_a_rvalid, o_a_rdata,
        output i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_lock,
        input  o_b_gnt, o_b_rvalid, o_b_rdata,
        input  o_mem_we, o_mem_addr, o_mem_wdata, o_mem_re,
        output i_mem_rdata
    );

endinterface

// File: rtl/ice51_mem_arb_pri.sv
// Combinational fixed-priority pick: A over B unless an override applies.
module ice51_arb_pri (
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_force_a,
    input  logic i_force_b,
    output logic o_a_pick,
    output logic o_b_pick
);

    // force_a beats force_b; B only takes what A does not.
    always_comb begin
        o_a_pick = i_a_req & (i_force_a | ~i_force_b);
        o_b_pick = i_b_req & ~o_a_pick;
    end

endmodule

// File: rtl/ice51_mem_arb.sv
// Two-requester arbiter for the shared single-port RAM: core (A) has
// priority bounded by a starvation counter; loader (B) may lock bursts.
module ice51_mem_arb #(
    parameter int ADDR_W     = ice51_pkg::CODE_ADDR_W,
    parameter int DATA_W     = ice51_pkg::DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 16
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    ice51_mem_arb_if.slave     bus
);

    import ice51_pkg::*;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);

    arb_state_t        state, state_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [7:0]        lock_cnt, lock_nxt, lock_inc;
    logic              a_first, a_first_nxt;
    logic              force_a, force_b, pick_a, pick_b;
    logic              gnt_a, gnt_b;
    logic              a_rvalid, b_rvalid;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Override selection: LOCK or a starved B takes the port, except right
    // after a forced lock exit where a waiting A goes first.
    always_comb begin
        force_a = (state == ARB_IDLE) & a_first & bus.i_a_req;
        force_b = (state == ARB_LOCK) |
                  ((starve_cnt == STARVE_LIM) & bus.i_b_req & ~force_a);
    end

    ice51_arb_pri u_pri (
        .i_a_req   (bus.i_a_req),
        .i_b_req   (bus.i_b_req),
        .i_force_a (force_a),
        .i_force_b (force_b),
        .o_a_pick  (pick_a),
        .o_b_pick  (pick_b)
    );

    // Grants are suppressed while reset is held.
    always_comb begin
        gnt_a = pick_a & i_nrst;
        gnt_b = pick_b & i_nrst;
    end

    // Next-state, lock counter and starvation counter.
    always_comb begin
        state_nxt   = state;
        lock_nxt    = lock_cnt;
        a_first_nxt = 1'b0;
        lock_inc    = lock_cnt + 8'd1;
        case (state)
            ARB_IDLE: begin
                if (gnt_b & bus.i_b_lock) begin
                    state_nxt = ARB_LOCK;
                    lock_nxt  = 8'd1;
                end
            end
            ARB_LOCK: begin
                if (gnt_b) lock_nxt = lock_inc;
                if (!bus.i_b_req || !bus.i_b_lock || (gnt_b && lock_inc == LOCK_LIM)) begin
                    state_nxt   = ARB_IDLE;
                    lock_nxt    = '0;
                    a_first_nxt = gnt_b & (lock_inc == LOCK_LIM);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (!bus.i_b_req || gnt_b || (state == ARB_LOCK && state_nxt == ARB_IDLE))
            starve_nxt = '0;
        else if (starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
        else
            starve_nxt = starve_cnt;
    end

    // State, counters and registered read-valid flags.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            a_first    <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            lock_cnt   <= lock_nxt;
            a_first    <= a_first_nxt;
            a_rvalid   <= gnt_a & ~bus.i_a_we;
            b_rvalid   <= gnt_b & ~bus.i_b_we;
        end
    end

    // Memory mux: the grantee drives the port, otherwise all zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_a) begin
            mem_we    = bus.i_a_we;
            mem_re    = ~bus.i_a_we;
            mem_addr  = bus.i_a_addr;
            mem_wdata = bus.i_a_wdata;
        end else if (gnt_b) begin
            mem_we    = bus.i_b_we;
            mem_re    = ~bus.i_b_we;
            mem_addr  = bus.i_b_addr;
            mem_wdata = bus.i_b_wdata;
        end
    end

    assign bus.o_a_gnt     = gnt_a;
    assign bus.o_b_gnt     = gnt_b;
    assign bus.o_a_rvalid  = a_rvalid;
    assign bus.o_b_rvalid  = b_rvalid;
    assign bus.o_a_rdata   = bus.i_mem_rdata;
    assign bus.o_b_rdata   = bus.i_mem_rdata;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_re    = mem_re;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = mem_wdata;

endmodule
